uart_cmd_master: RTL

Host-side initiator for the DOM UART register protocol; it is the other end of the link from the on-board command processor. It takes one register command at a time (single or burst, read or write) from local logic and serializes it into header, PID, length, address, data and CRC bytes over a byte-wide req/ack UART PHY interface. For reads it collects the response words, checks the trailing CRC and delivers the words to local logic. It sits between a host-side controller (test sequencer or bridge FIFO) and the UART PHY.

---
 rtl/uart_proto_pkg.sv | 51 +++++
 rtl/uart_byte_tx_hs.sv | 47 ++++
 rtl/uart_cmd_master.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_proto_pkg.sv
// uart_proto_pkg: constants, state codes and CRC step shared by the DOM UART master and responder
package uart_proto_pkg;

    localparam logic [7:0] L_HDR1        = 8'h8F;
    localparam logic [7:0] L_HDR0        = 8'hC7;
    localparam logic [7:0] L_PID1_SINGLE = 8'h00;
    localparam logic [7:0] L_PID1_BURST  = 8'h80;
    localparam logic [7:0] L_PID0_WR     = 8'h01;
    localparam logic [7:0] L_PID0_RD     = 8'h02;

    localparam logic [1:0] E_OK      = 2'd0;
    localparam logic [1:0] E_CRC     = 2'd1;
    localparam logic [1:0] E_TIMEOUT = 2'd2;
    localparam logic [1:0] E_LEN     = 2'd3;

    // TX states are contiguous (S_HDR1..S_WR_CRC0) so the master can range-check them
    localparam logic [4:0] S_IDLE     = 5'd0;
    localparam logic [4:0] S_HDR1     = 5'd1;
    localparam logic [4:0] S_HDR0     = 5'd2;
    localparam logic [4:0] S_PID1     = 5'd3;
    localparam logic [4:0] S_PID0     = 5'd4;
    localparam logic [4:0] S_LEN1     = 5'd5;
    localparam logic [4:0] S_LEN0     = 5'd6;
    localparam logic [4:0] S_ADR1     = 5'd7;
    localparam logic [4:0] S_ADR0     = 5'd8;
    localparam logic [4:0] S_WR_DATA1 = 5'd9;
    localparam logic [4:0] S_WR_DATA0 = 5'd10;
    localparam logic [4:0] S_WR_CRC1  = 5'd11;
    localparam logic [4:0] S_WR_CRC0  = 5'd12;
    localparam logic [4:0] S_RD_DATA1 = 5'd13;
    localparam logic [4:0] S_RD_DATA0 = 5'd14;
    localparam logic [4:0] S_RD_CRC1  = 5'd15;
    localparam logic [4:0] S_RD_CRC0  = 5'd16;
    localparam logic [4:0] S_DONE     = 5'd17;

`ifdef MODEL_TECH
    localparam int unsigned L_TIMEOUT_DEFAULT = 1000;
`else
    localparam int unsigned L_TIMEOUT_DEFAULT = 100000000;
`endif

    // CRC-16 poly 0x8005, MSB first, one byte per call
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] r;
        r = crc;
        for (int i = 7; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ data[i]) ? 16'h8005 : 16'h0000);
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_tx_hs.sv
// uart_byte_tx_hs: sends one byte over the 4-phase req/ack PHY handshake
module uart_byte_tx_hs (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] byte_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       tx_req_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ack_i
);

    logic       busy_q, req_q, ack_q;
    logic [7:0] data_q;

    // byte completes on the falling edge of ack, only while a byte is in flight
    assign done_o    = busy_q && ack_q && !tx_ack_i;
    assign busy_o    = busy_q;
    assign tx_req_o  = req_q;
    assign tx_data_o = data_q;

    // hold data, raise req, drop req once ack is seen, free up on ack fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            req_q  <= 1'b0;
            ack_q  <= 1'b0;
            data_q <= 8'h00;
        end else begin
            ack_q <= tx_ack_i;
            if (abort_i) begin
                busy_q <= 1'b0;
                req_q  <= 1'b0;
            end else if (start_i && !busy_q) begin
                busy_q <= 1'b1;
                req_q  <= 1'b1;
                data_q <= byte_i;
            end else begin
                if (req_q && tx_ack_i) req_q <= 1'b0;
                if (done_o) busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: host-side DOM UART register command initiator (single/burst, read/write)
module uart_cmd_master
    import uart_proto_pkg::*;
#(
    parameter int unsigned P_TIMEOUT_CNT_MAX = L_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_rd,
    input  logic        cmd_burst,
    input  logic [15:0] cmd_len,
    input  logic [11:0] cmd_adr,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [1:0]  cmd_err,
    output logic        wr_data_rd,
    input  logic [15:0] wr_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_ack,
    input  logic        rx_req,
    input  logic [7:0]  rx_data,
    output logic        rx_ack
);

    logic [4:0]  state_q, state_d;
    logic [31:0] to_q;
    logic [15:0] cnt_q, cnt_d, crc_q, crc_d, wd_q, rd_data_q;
    logic [11:0] adr_q;
    logic [7:0]  tx_byte, rx_byte_q, rhi_q;
    logic [1:0]  err_q, err_d;
    logic        rd_q, burst_q, rd_valid_q, rd_valid_d, rx_ack_q;
    logic        is_tx, tx_start, tx_busy, tx_done, timeout, rx_consume;

    assign is_tx      = state_q >= S_HDR1 && state_q <= S_WR_CRC0;
    assign tx_start   = is_tx && !tx_busy;
    assign timeout    = state_q != S_IDLE && state_q != S_DONE && to_q == P_TIMEOUT_CNT_MAX - 1;
    assign rx_consume = rx_ack_q && !rx_req;
    assign wr_data_rd = state_d == S_WR_DATA1 && state_q != S_WR_DATA1;
    assign cmd_busy   = state_q != S_IDLE;
    assign cmd_done   = state_q == S_DONE;
    assign cmd_err    = (state_q == S_DONE) ? err_q : E_OK;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign rx_ack     = rx_ack_q;

    uart_byte_tx_hs u_tx (
        .clk       (clk),
        .rst       (rst),
        .start_i   (tx_start),
        .abort_i   (timeout),
        .byte_i    (tx_byte),
        .busy_o    (tx_busy),
        .done_o    (tx_done),
        .tx_req_o  (tx_req),
        .tx_data_o (tx_data),
        .tx_ack_i  (tx_ack)
    );

    // byte to send in each TX state
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            S_HDR1:     tx_byte = L_HDR1;
            S_HDR0:     tx_byte = L_HDR0;
            S_PID1:     tx_byte = burst_q ? L_PID1_BURST : L_PID1_SINGLE;
            S_PID0:     tx_byte = rd_q ? L_PID0_RD : L_PID0_WR;
            S_LEN1:     tx_byte = cnt_q[15:8];
            S_LEN0:     tx_byte = cnt_q[7:0];
            S_ADR1:     tx_byte = {4'h0, adr_q[11:8]};
            S_ADR0:     tx_byte = adr_q[7:0];
            S_WR_DATA1: tx_byte = wd_q[15:8];
            S_WR_DATA0: tx_byte = wd_q[7:0];
            S_WR_CRC1:  tx_byte = crc_q[15:8];
            S_WR_CRC0:  tx_byte = crc_q[7:0];
            default:    tx_byte = 8'h00;
        endcase
    end

    // command sequencing, word counting, CRC accumulation and status
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        if (tx_start && state_q >= S_ADR1 && state_q <= S_WR_DATA0) crc_d = crc16_step(crc_q, tx_byte);
        case (state_q)
            S_IDLE: begin
                crc_d = 16'hFFFF;
                if (cmd_valid) begin
                    state_d = (cmd_burst && cmd_len == 16'd0) ? S_DONE : S_HDR1;
                    err_d   = (cmd_burst && cmd_len == 16'd0) ? E_LEN : E_OK;
                    cnt_d   = cmd_burst ? cmd_len : 16'd1;
                end
            end
            S_PID0:     if (tx_done) state_d = burst_q ? S_LEN1 : S_ADR1;
            S_ADR0:     if (tx_done) state_d = rd_q ? S_RD_DATA1 : S_WR_DATA1;
            S_WR_DATA0: if (tx_done) begin
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_d == 16'd0) ? S_WR_CRC1 : S_WR_DATA1;
            end
            S_WR_CRC0:  if (tx_done) state_d = S_DONE;
            S_RD_DATA1: if (rx_consume) begin
                crc_d   = crc16_step(crc_q, rx_byte_q);
                state_d = S_RD_DATA0;
            end
            S_RD_DATA0: if (rx_consume) begin
                crc_d      = crc16_step(crc_q, rx_byte_q);
                cnt_d      = cnt_q - 16'd1;
                rd_valid_d = 1'b1;
                state_d    = (cnt_d == 16'd0) ? S_RD_CRC1 : S_RD_DATA1;
            end
            S_RD_CRC1:  if (rx_consume) state_d = S_RD_CRC0;
            S_RD_CRC0:  if (rx_consume) begin
                err_d   = ({rhi_q, rx_byte_q} == crc_q) ? E_OK : E_CRC;
                state_d = S_DONE;
            end
            S_DONE:     state_d = S_IDLE;
            default:    if (is_tx && tx_done) state_d = state_q + 5'd1;
        endcase
        if (timeout) begin
            state_d = S_DONE;
            err_d   = E_TIMEOUT;
        end
    end

    // FSM, per-state timeout counter and latched command fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            to_q       <= 32'd0;
            cnt_q      <= 16'd0;
            crc_q      <= 16'd0;
            err_q      <= E_OK;
            rd_valid_q <= 1'b0;
            adr_q      <= 12'h000;
            rd_q       <= 1'b0;
            burst_q    <= 1'b0;
            wd_q       <= 16'h0000;
        end else begin
            state_q    <= state_d;
            to_q       <= (state_d != state_q || state_q == S_IDLE) ? 32'd0 : to_q + 32'd1;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            if (state_q == S_IDLE && cmd_valid) begin
                adr_q   <= cmd_adr;
                rd_q    <= cmd_rd;
                burst_q <= cmd_burst;
            end
            if (wr_data_rd) wd_q <= wr_data;
        end
    end

    // RX handshake: ack and latch on req, release on req drop; abort drops ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ack_q  <= 1'b0;
            rx_byte_q <= 8'h00;
        end else if (timeout) begin
            rx_ack_q <= 1'b0;
        end else if (!rx_ack_q && rx_req) begin
            rx_ack_q  <= 1'b1;
            rx_byte_q <= rx_data;
        end else if (rx_consume) begin
            rx_ack_q <= 1'b0;
        end
    end

    // assemble read words; high byte of each word and of the CRC is held until the low byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rhi_q     <= 8'h00;
            rd_data_q <= 16'h0000;
        end else if (rx_consume) begin
            if (state_q == S_RD_DATA1 || state_q == S_RD_CRC1) rhi_q <= rx_byte_q;
            if (state_q == S_RD_DATA0) rd_data_q <= {rhi_q, rx_byte_q};
        end
    end

endmodule
